// File: rtl/rip_branch_predictor_const.sv
// Shared branch predictor types: table index, 2-bit counter and the
// per-branch metadata carried from fetch to resolve.
package rip_branch_predictor_const;

   localparam int BP_INDEX_W = 8;

   typedef logic [BP_INDEX_W-1:0] bp_index_t;

   typedef enum logic [1:0] {
      STRONGLY_NOT_TAKEN = 2'b00,
      WEAKLY_NOT_TAKEN   = 2'b01,
      WEAKLY_TAKEN       = 2'b10,
      STRONGLY_TAKEN     = 2'b11
   } bp_weight_t;

   typedef struct packed {
      bp_index_t   index;
      bp_weight_t  weight;
      logic        pred;
      logic [31:0] pc;
      logic [31:0] npc;
   } bp_meta_t;

   function automatic logic [31:0] bp_seq_pc(
      input logic [31:0] pc
   );
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/rip_bp_meta_fifo.sv
// In-order metadata store for in-flight branches.
// Flush wins over push and pop and leaves the queue empty.
module rip_bp_meta_fifo
   import rip_branch_predictor_const::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush_i,
   input  logic           push_i,
   input  bp_meta_t       wdata_i,
   input  logic           pop_i,
   output bp_meta_t       rdata_o,
   output logic [PTR_W:0] count_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

   bp_meta_t         mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == FULL_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/rip_branch_resolve_queue.sv
// Branch resolve queue: predictor update and mispredict redirect.
// Optional BP_STATS_EN builds saturating resolve/mispredict counters.
module rip_branch_resolve_queue
   import rip_branch_predictor_const::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall,
   input  logic           push_valid,
   output logic           push_ready,
   input  bp_index_t      push_index,
   input  bp_weight_t     push_weight,
   input  logic           push_pred,
   input  logic [31:0]    push_pc,
   input  logic [31:0]    push_npc,
   input  logic           resolve_valid,
   input  logic           resolve_taken,
   input  logic [31:0]    resolve_target,
   output logic           update,
   output bp_index_t      update_index,
   output bp_weight_t     update_weight,
   output logic           actual,
   output logic           redirect,
   output logic [31:0]    redirect_pc,
   output logic [PTR_W:0] count,
   output logic [31:0]    stat_branches,
   output logic [31:0]    stat_mispred
);

   bp_meta_t    push_meta;
   bp_meta_t    head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push_acc;
   logic        res_acc;
   logic        mispred;
   logic        flush;
   logic [31:0] corr_pc;

   logic        update_q,        update_d;
   logic        redirect_q,      redirect_d;
   logic        actual_q,        actual_d;
   bp_index_t   update_index_q,  update_index_d;
   bp_weight_t  update_weight_q, update_weight_d;
   logic [31:0] redirect_pc_q,   redirect_pc_d;

   assign push_meta = '{
      index:  push_index,
      weight: push_weight,
      pred:   push_pred,
      pc:     push_pc,
      npc:    push_npc
   };

   assign push_ready = ~fifo_full;
   assign push_acc   = push_valid & ~fifo_full & ~stall;
   assign res_acc    = resolve_valid & ~fifo_empty & ~stall;

   assign mispred = (resolve_taken != head.pred)
                  | (resolve_taken & (resolve_target != head.npc));
   assign corr_pc = resolve_taken ? resolve_target
                                  : bp_seq_pc(head.pc);
   assign flush   = res_acc & mispred;

   rip_bp_meta_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .push_i  (push_acc),
      .wdata_i (push_meta),
      .pop_i   (res_acc),
      .rdata_o (head),
      .count_o (count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Strobes hold under stall so a resolve is never lost, only delayed.
   always_comb begin
      update_d        = update_q;
      redirect_d      = redirect_q;
      actual_d        = actual_q;
      update_index_d  = update_index_q;
      update_weight_d = update_weight_q;
      redirect_pc_d   = redirect_pc_q;
      if (!stall) begin
         update_d   = res_acc;
         redirect_d = flush;
      end
      if (res_acc) begin
         actual_d        = resolve_taken;
         update_index_d  = head.index;
         update_weight_d = head.weight;
         redirect_pc_d   = corr_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         update_q        <= 1'b0;
         redirect_q      <= 1'b0;
         actual_q        <= 1'b0;
         update_index_q  <= '0;
         update_weight_q <= STRONGLY_NOT_TAKEN;
         redirect_pc_q   <= '0;
      end else begin
         update_q        <= update_d;
         redirect_q      <= redirect_d;
         actual_q        <= actual_d;
         update_index_q  <= update_index_d;
         update_weight_q <= update_weight_d;
         redirect_pc_q   <= redirect_pc_d;
      end
   end

   assign update        = update_q & ~stall;
   assign redirect      = redirect_q & ~stall;
   assign actual        = actual_q;
   assign update_index  = update_index_q;
   assign update_weight = update_weight_q;
   assign redirect_pc   = redirect_pc_q;

`ifdef BP_STATS_EN
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mp_cnt_q, mp_cnt_d;

   always_comb begin
      br_cnt_d = br_cnt_q;
      mp_cnt_d = mp_cnt_q;
      if (res_acc && br_cnt_q != 32'hFFFF_FFFF)
         br_cnt_d = br_cnt_q + 32'd1;
      if (flush && mp_cnt_q != 32'hFFFF_FFFF)
         mp_cnt_d = mp_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         br_cnt_q <= br_cnt_d;
         mp_cnt_q <= mp_cnt_d;
      end
   end

   assign stat_branches = br_cnt_q;
   assign stat_mispred  = mp_cnt_q;
`else
   assign stat_branches = 32'd0;
   assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_rip_branch_resolve_queue.sv
// Directed bench for rip_branch_resolve_queue (DEPTH=4).
// Stats expectations follow BP_STATS_EN.
module tb_rip_branch_resolve_queue;
   import rip_branch_predictor_const::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        push_valid;
   logic        push_ready;
   bp_index_t   push_index;
   bp_weight_t  push_weight;
   logic        push_pred;
   logic [31:0] push_pc;
   logic [31:0] push_npc;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [31:0] resolve_target;
   logic        update;
   bp_index_t   update_index;
   bp_weight_t  update_weight;
   logic        actual;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  count;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;

   int errors = 0;
   int checks = 0;

   rip_branch_resolve_queue #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .push_valid     (push_valid),
      .push_ready     (push_ready),
      .push_index     (push_index),
      .push_weight    (push_weight),
      .push_pred      (push_pred),
      .push_pc        (push_pc),
      .push_npc       (push_npc),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .resolve_target (resolve_target),
      .update         (update),
      .update_index   (update_index),
      .update_weight  (update_weight),
      .actual         (actual),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .count          (count),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input bp_index_t idx, input bp_weight_t w,
                           input logic pred, input logic [31:0] pc,
                           input logic [31:0] npc);
      push_valid  = 1'b1;
      push_index  = idx;
      push_weight = w;
      push_pred   = pred;
      push_pc     = pc;
      push_npc    = npc;
   endtask

   task automatic do_push(input bp_index_t idx, input bp_weight_t w,
                          input logic pred, input logic [31:0] pc,
                          input logic [31:0] npc);
      set_push(idx, w, pred, pc, npc);
      step();
      push_valid = 1'b0;
   endtask

   task automatic idle();
      push_valid    = 1'b0;
      resolve_valid = 1'b0;
      stall         = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("FAIL reset_count got %0d exp 0", count);
      end
      checks++;
      if (push_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b exp 1", push_ready);
      end
      checks++;
      if ({update, redirect, actual} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes got %b exp 000",
                  {update, redirect, actual});
      end
      checks++;
      if (redirect_pc !== 32'd0 || update_index !== '0 ||
          update_weight !== STRONGLY_NOT_TAKEN) begin
         errors++;
         $display("FAIL reset_data got pc=%h idx=%0d w=%0d exp 0",
                  redirect_pc, update_index, update_weight);
      end
      checks++;
      if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
         errors++;
         $display("FAIL reset_stats got %0d/%0d exp 0/0",
                  stat_branches, stat_mispred);
      end
   endtask

   task automatic test_correct();
      do_push(8'd5, WEAKLY_TAKEN, 1'b1, 32'h100, 32'h200);
      checks++;
      if (count !== 3'd1) begin
         errors++;
         $display("FAIL corr_push_count got %0d exp 1", count);
      end
      resolve_valid  = 1'b1;
      resolve_taken  = 1'b1;
      resolve_target = 32'h200;
      step();
      resolve_valid = 1'b0;
      checks++;
      if (update !== 1'b1 || update_index !== 8'd5 ||
          update_weight !== WEAKLY_TAKEN || actual !== 1'b1) begin
         errors++;
         $display("FAIL corr_update got u=%b i=%0d w=%0d a=%b exp 1/5/2/1",
                  update, update_index, update_weight, actual);
      end
      checks++;
      if (redirect !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL corr_redir got r=%b c=%0d exp 0/0",
                  redirect, count);
      end
      step();
      checks++;
      if (update !== 1'b0) begin
         errors++;
         $display("FAIL corr_pulse got %b exp 0", update);
      end
   endtask

   task automatic test_mispredict();
      do_push(8'd5, WEAKLY_TAKEN, 1'b1, 32'h100, 32'h200);
      do_push(8'd6, WEAKLY_NOT_TAKEN, 1'b0, 32'h200, 32'h204);
      do_push(8'd7, STRONGLY_TAKEN, 1'b1, 32'h204, 32'h280);
      do_push(8'd8, WEAKLY_TAKEN, 1'b1, 32'h280, 32'h300);
      checks++;
      if (count !== 3'd4) begin
         errors++;
         $display("FAIL mis_fill got %0d exp 4", count);
      end
      resolve_valid  = 1'b1;
      resolve_taken  = 1'b0;
      resolve_target = 32'h0;
      step();
      resolve_valid = 1'b0;
      checks++;
      if (redirect !== 1'b1 || redirect_pc !== 32'h104 ||
          actual !== 1'b0 || update !== 1'b1 ||
          update_index !== 8'd5) begin
         errors++;
         $display("FAIL mis_nt got r=%b pc=%h a=%b u=%b i=%0d exp 1/104/0/1/5",
                  redirect, redirect_pc, actual, update, update_index);
      end
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("FAIL mis_flush got %0d exp 0", count);
      end
      step();
      checks++;
      if (redirect !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL mis_pulse got r=%b c=%0d exp 0/0",
                  redirect, count);
      end
      // wrong taken target plus a same-cycle push that must be discarded
      do_push(8'd9, WEAKLY_TAKEN, 1'b1, 32'h300, 32'h400);
      set_push(8'd10, WEAKLY_TAKEN, 1'b0, 32'h500, 32'h504);
      resolve_valid  = 1'b1;
      resolve_taken  = 1'b1;
      resolve_target = 32'h480;
      step();
      idle();
      checks++;
      if (redirect !== 1'b1 || redirect_pc !== 32'h480 ||
          count !== 3'd0) begin
         errors++;
         $display("FAIL mis_tgt got r=%b pc=%h c=%0d exp 1/480/0",
                  redirect, redirect_pc, count);
      end
      step();
   endtask

   task automatic test_full();
      for (int k = 1; k <= 4; k++) begin
         do_push(8'(k), WEAKLY_NOT_TAKEN, 1'b0,
                 32'(k * 16), 32'(k * 16 + 4));
      end
      checks++;
      if (push_ready !== 1'b0 || count !== 3'd4) begin
         errors++;
         $display("FAIL full_ready got r=%b c=%0d exp 0/4",
                  push_ready, count);
      end
      set_push(8'd15, WEAKLY_TAKEN, 1'b0, 32'hF0, 32'hF4);
      resolve_valid  = 1'b1;
      resolve_taken  = 1'b0;
      resolve_target = 32'h0;
      step();
      push_valid = 1'b0;
      checks++;
      if (count !== 3'd3 || push_ready !== 1'b1 ||
          update_index !== 8'd1 || redirect !== 1'b0) begin
         errors++;
         $display("FAIL full_pop got c=%0d r=%b i=%0d rd=%b exp 3/1/1/0",
                  count, push_ready, update_index, redirect);
      end
      for (int k = 2; k <= 4; k++) begin
         step();
         checks++;
         if (update_index !== 8'(k) || count !== 3'(4 - k)) begin
            errors++;
            $display("FAIL full_drain got i=%0d c=%0d exp %0d/%0d",
                     update_index, count, k, 4 - k);
         end
      end
      resolve_valid = 1'b0;
      step();
      do_push(8'd20, WEAKLY_TAKEN, 1'b0, 32'h600, 32'h604);
      set_push(8'd21, WEAKLY_TAKEN, 1'b0, 32'h604, 32'h608);
      resolve_valid = 1'b1;
      step();
      push_valid = 1'b0;
      checks++;
      if (count !== 3'd1 || update_index !== 8'd20) begin
         errors++;
         $display("FAIL b2b_keep got c=%0d i=%0d exp 1/20",
                  count, update_index);
      end
      step();
      resolve_valid = 1'b0;
      checks++;
      if (count !== 3'd0 || update_index !== 8'd21 ||
          update !== 1'b1) begin
         errors++;
         $display("FAIL b2b_next got c=%0d i=%0d u=%b exp 0/21/1",
                  count, update_index, update);
      end
      step();
   endtask

   task automatic test_empty_resolve();
      resolve_valid  = 1'b1;
      resolve_taken  = 1'b1;
      resolve_target = 32'h700;
      step();
      step();
      resolve_valid = 1'b0;
      checks++;
      if (update !== 1'b0 || redirect !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL empty_res got u=%b r=%b c=%0d exp 0/0/0",
                  update, redirect, count);
      end
   endtask

   task automatic test_stall();
      do_push(8'd7, STRONGLY_NOT_TAKEN, 1'b0, 32'h40, 32'h44);
      stall          = 1'b1;
      resolve_valid  = 1'b1;
      resolve_taken  = 1'b0;
      resolve_target = 32'h0;
      set_push(8'd8, WEAKLY_TAKEN, 1'b1, 32'h44, 32'h90);
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (update !== 1'b0 || redirect !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL stall_hold got u=%b r=%b c=%0d exp 0/0/1",
                     update, redirect, count);
         end
      end
      stall      = 1'b0;
      push_valid = 1'b0;
      step();
      resolve_valid = 1'b0;
      checks++;
      if (update !== 1'b1 || update_index !== 8'd7 ||
          redirect !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL stall_release got u=%b i=%0d r=%b c=%0d exp 1/7/0/0",
                  update, update_index, redirect, count);
      end
      step();
   endtask

   task automatic test_rst_mid();
      do_push(8'd30, WEAKLY_TAKEN, 1'b0, 32'h800, 32'h804);
      do_push(8'd31, WEAKLY_TAKEN, 1'b0, 32'h804, 32'h808);
      resolve_valid  = 1'b1;
      resolve_taken  = 1'b1;
      resolve_target = 32'h900;
      rst            = 1'b1;
      step();
      rst           = 1'b0;
      resolve_valid = 1'b0;
      checks++;
      if (update !== 1'b0 || redirect !== 1'b0 || count !== 3'd0 ||
          push_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid got u=%b r=%b c=%0d rdy=%b exp 0/0/0/1",
                  update, redirect, count, push_ready);
      end
   endtask

   task automatic test_stats();
      logic [31:0] exp_br;
      logic [31:0] exp_mp;
      logic        mis;
      logic [31:0] pc;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         mis = (i == 2 || i == 5 || i == 8);
         pc  = 32'h1000 + 32'(i * 16);
         do_push(8'(i), WEAKLY_TAKEN, 1'b1, pc, pc + 32'h40);
         resolve_valid  = 1'b1;
         resolve_taken  = 1'b1;
         resolve_target = mis ? pc + 32'h44 : pc + 32'h40;
         step();
         resolve_valid = 1'b0;
      end
`ifdef BP_STATS_EN
      exp_br = 32'd10;
      exp_mp = 32'd3;
`else
      exp_br = 32'd0;
      exp_mp = 32'd0;
`endif
      checks++;
      if (stat_branches !== exp_br || stat_mispred !== exp_mp) begin
         errors++;
         $display("FAIL stats_count got %0d/%0d exp %0d/%0d",
                  stat_branches, stat_mispred, exp_br, exp_mp);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
         errors++;
         $display("FAIL stats_rst got %0d/%0d exp 0/0",
                  stat_branches, stat_mispred);
      end
   endtask

   initial begin
      rst            = 1'b1;
      stall          = 1'b0;
      push_valid     = 1'b0;
      push_index     = '0;
      push_weight    = STRONGLY_NOT_TAKEN;
      push_pred      = 1'b0;
      push_pc        = '0;
      push_npc       = '0;
      resolve_valid  = 1'b0;
      resolve_taken  = 1'b0;
      resolve_target = '0;
      test_reset();
      test_correct();
      test_mispredict();
      test_full();
      test_empty_resolve();
      test_stall();
      test_rst_mid();
      test_stats();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
